// File: rtl/addsub_pipe_36bits.sv
// Two-stage 36-bit add/sub: operands registered in S1, sum and flags in S2; result valid two edges after the op is presented.
// Stalls hold both stages and in_ready = ~s1_valid | s2_adv. Define ADDSUB_PIPE_SAT_EN to clamp overflowed results.
module addsub_pipe_36bits #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [35:0]      in_a,
  input  logic [35:0]      in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [35:0]      out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n,
  output logic [CNT_W-1:0] op_count
);
  localparam int W    = 36;
  localparam int GRP  = 4;
  localparam int NGRP = W / GRP;

  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_a_q, s1_b_q;
  logic             s1_cin_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q, s2_valid_d;
  logic [W-1:0]     s2_sum_q, s2_sum_d;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_c_q, s2_c_d;
  logic             s2_v_q, s2_v_d;
  logic             s2_z_q, s2_z_d;
  logic             s2_n_q, s2_n_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             s1_load, s2_adv, out_fire;

  logic [W-1:0]     p, g, sum_raw;
  logic [NGRP-1:0]  gp, gg;
  logic             gm, pm, cc, gcar;

  assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_adv;
  assign s1_load  = in_valid & in_ready;
  assign out_fire = s2_valid_q & out_ready;

  // Carry-lookahead core: 4-bit groups, group P/G chained for the overall gm/pm.
  always_comb begin
    p       = s1_a_q ^ s1_b_q;
    g       = s1_a_q & s1_b_q;
    gp      = '0;
    gg      = '0;
    gm      = 1'b0;
    pm      = 1'b1;
    cc      = 1'b0;
    gcar    = s1_cin_q;
    sum_raw = '0;
    for (int k = 0; k < NGRP; k++) begin
      gp[k] = &p[k*GRP +: GRP];
      gg[k] = g[k*GRP+3]
            | (p[k*GRP+3] & g[k*GRP+2])
            | (p[k*GRP+3] & p[k*GRP+2] & g[k*GRP+1])
            | ((&p[k*GRP+1 +: 3]) & g[k*GRP]);
      gm    = gg[k] | (gp[k] & gm);
      pm    = pm & gp[k];
      cc    = gcar;
      for (int j = 0; j < GRP; j++) begin
        sum_raw[k*GRP+j] = p[k*GRP+j] ^ cc;
        cc               = g[k*GRP+j] | (p[k*GRP+j] & cc);
      end
      gcar  = gg[k] | (gp[k] & gcar);
    end
  end

  always_comb begin
    s2_c_d   = gm | (pm & s1_cin_q);
    s2_v_d   = (s1_a_q[W-1] == s1_b_q[W-1]) & (sum_raw[W-1] != s1_a_q[W-1]);
    s2_sum_d = sum_raw;
`ifdef ADDSUB_PIPE_SAT_EN
    // On overflow the true result has the sign of a, so clamp toward it.
    if (s2_v_d) begin
      s2_sum_d = s1_a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
    s2_z_d   = ~|s2_sum_d;
    s2_n_d   = s2_sum_d[W-1];
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
    s2_valid_d = s2_adv | (s2_valid_q & ~out_ready);
    cnt_d      = cnt_q;
    if (out_fire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // cin doubles as the subtract flag, so it is the only per-op mode bit kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_a_q   <= in_a;
        s1_b_q   <= in_b ^ {W{in_sub}};
        s1_cin_q <= in_sub;
        s1_tag_q <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_tag_q   <= '0;
      s2_c_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s2_z_q     <= 1'b0;
      s2_n_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
      if (s2_adv) begin
        s2_sum_q <= s2_sum_d;
        s2_tag_q <= s1_tag_q;
        s2_c_q   <= s2_c_d;
        s2_v_q   <= s2_v_d;
        s2_z_q   <= s2_z_d;
        s2_n_q   <= s2_n_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = s2_sum_q;
  assign out_tag   = s2_tag_q;
  assign out_c     = s2_c_q;
  assign out_v     = s2_v_q;
  assign out_z     = s2_z_q;
  assign out_n     = s2_n_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_addsub_pipe_36bits.sv
// Bench for addsub_pipe_36bits: directed arithmetic cases plus randomized handshake traffic
// scored against a signed/unsigned arithmetic model and an occupancy-based ready model.
module tb_addsub_pipe_36bits;
  localparam int TAG_W = 4;
  localparam int CNT_W = 16;
  localparam longint SMAX = 64'sd34359738367;
  localparam longint SMIN = -64'sd34359738368;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [35:0]      in_a = '0;
  logic [35:0]      in_b = '0;
  logic             in_sub = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [35:0]      out_sum;
  logic [TAG_W-1:0] out_tag;
  logic             out_c, out_v, out_z, out_n;
  logic [CNT_W-1:0] op_count;

  int checks = 0;
  int errors = 0;
  int unsigned exp_cnt = 0;

  typedef struct packed {
    logic [35:0]      sum;
    logic [TAG_W-1:0] tag;
    logic             c, v, z, n;
  } res_t;

  typedef struct packed {
    logic in_fire, out_fire, in_rdy, out_vld;
    res_t res;
  } samp_t;

  res_t expq[$];

  always #5 clk = ~clk;

  addsub_pipe_36bits #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_tag(out_tag),
    .out_c(out_c), .out_v(out_v), .out_z(out_z), .out_n(out_n),
    .op_count(op_count)
  );

  function automatic res_t model(input logic [35:0] a, input logic [35:0] b,
                                 input logic sub, input logic [TAG_W-1:0] tag);
    longint sa, sb, r;
    longint unsigned ua, ub, ur;
    res_t e;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      r = sa - sb;
      ur = ua - ub;
      e.c = (ua >= ub);
    end else begin
      r = sa + sb;
      ur = ua + ub;
      e.c = ur[36];
    end
    e.v = (r > SMAX) || (r < SMIN);
    e.sum = ur[35:0];
`ifdef ADDSUB_PIPE_SAT_EN
    if (e.v) e.sum = (r > 0) ? 36'h7FFFFFFFF : 36'h800000000;
`endif
    e.z = (e.sum == 36'h0);
    e.n = e.sum[35];
    e.tag = tag;
    return e;
  endfunction

  function automatic logic [35:0] rnd36();
    case ($urandom_range(7, 0))
      0: return 36'h000000000;
      1: return 36'hFFFFFFFFF;
      2: return 36'h7FFFFFFFF;
      3: return 36'h800000000;
      default: return {4'($urandom), 32'($urandom)};
    endcase
  endfunction

  // Samples the cycle's handshake just before the edge, then moves to 1 time unit past it.
  task automatic cycle(output samp_t s);
    #1;
    s.in_fire  = in_valid & in_ready;
    s.out_fire = out_valid & out_ready;
    s.in_rdy   = in_ready;
    s.out_vld  = out_valid;
    s.res      = {out_sum, out_tag, out_c, out_v, out_z, out_n};
    if (s.out_fire && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [35:0] a, input logic [35:0] b,
                       input logic sub, input logic [TAG_W-1:0] tag);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_sub = sub;
    in_tag = tag;
  endtask

  task automatic run_one(input logic [35:0] a, input logic [35:0] b, input logic sub,
                         input logic [TAG_W-1:0] tag, output res_t got, output bit ok);
    samp_t s;
    int n;
    got = '0;
    ok = 1'b0;
    out_ready = 1'b1;
    drive(a, b, sub, tag);
    n = 0;
    do begin cycle(s); n++; end while (!s.in_fire && n < 20);
    in_valid = 1'b0;
    if (s.in_fire) begin
      n = 0;
      do begin cycle(s); n++; end while (!s.out_fire && n < 20);
      ok = s.out_fire;
      got = s.res;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({out_valid, out_sum, out_tag, out_c, out_v, out_z, out_n, op_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {out_valid, out_sum, out_tag, out_c, out_v, out_z, out_n, op_count});
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    samp_t s;
    res_t want;
    out_ready = 1'b1;
    drive(36'h5, 36'h3, 1'b0, 4'd1);
    cycle(s);
    in_valid = 1'b0;
    checks++;
    if (s.in_fire !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept: got %b required 1", s.in_fire);
    end
    cycle(s);
    checks++;
    if (s.out_vld !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: got %b required 0", s.out_vld);
    end
    cycle(s);
    checks++;
    if (s.out_vld !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: got out_valid %b required 1", s.out_vld);
    end
    want = {36'h8, 4'd1, 4'b0000};
    checks++;
    if (s.res !== want) begin
      errors++;
      $display("FAIL basic_result: got %h required %h", s.res, want);
    end
    checks++;
    if (op_count !== 16'd1) begin
      errors++;
      $display("FAIL basic_op_count: got %0d required 1", op_count);
    end
  endtask

  task automatic test_sub_borrow();
    res_t got, want;
    bit ok;
    run_one(36'h7, 36'h7, 1'b1, 4'd2, got, ok);
    want = {36'h0, 4'd2, 4'b1010};
    checks++;
    if (!ok || got !== want) begin
      errors++;
      $display("FAIL sub_zero: got %h (done %b) required %h", got, ok, want);
    end
    run_one(36'h3, 36'h5, 1'b1, 4'd3, got, ok);
    want = {36'hFFFFFFFFE, 4'd3, 4'b0001};
    checks++;
    if (!ok || got !== want) begin
      errors++;
      $display("FAIL sub_borrow: got %h (done %b) required %h", got, ok, want);
    end
  endtask

  task automatic test_carry_overflow();
    res_t got, want;
    bit ok;
    run_one(36'hFFFFFFFFF, 36'h1, 1'b0, 4'd4, got, ok);
    want = {36'h0, 4'd4, 4'b1010};
    checks++;
    if (!ok || got !== want) begin
      errors++;
      $display("FAIL carry_wrap: got %h (done %b) required %h", got, ok, want);
    end
    run_one(36'h7FFFFFFFF, 36'h1, 1'b0, 4'd5, got, ok);
`ifdef ADDSUB_PIPE_SAT_EN
    want = {36'h7FFFFFFFF, 4'd5, 4'b0100};
`else
    want = {36'h800000000, 4'd5, 4'b0101};
`endif
    checks++;
    if (!ok || got !== want) begin
      errors++;
      $display("FAIL pos_overflow: got %h (done %b) required %h", got, ok, want);
    end
    run_one(36'h800000000, 36'h1, 1'b1, 4'd6, got, ok);
`ifdef ADDSUB_PIPE_SAT_EN
    want = {36'h800000000, 4'd6, 4'b1101};
`else
    want = {36'h7FFFFFFFF, 4'd6, 4'b1100};
`endif
    checks++;
    if (!ok || got !== want) begin
      errors++;
      $display("FAIL neg_overflow: got %h (done %b) required %h", got, ok, want);
    end
  endtask

  task automatic test_stream();
    samp_t s;
    int nin, nout;
    int unsigned base;
    out_ready = 1'b1;
    expq.delete();
    base = exp_cnt;
    nin = 0;
    nout = 0;
    for (int k = 0; k < 40 && nout < 10; k++) begin
      if (nin < 10) drive(rnd36(), rnd36(), 1'($urandom), 4'(nin));
      else in_valid = 1'b0;
      cycle(s);
      if (nin < 10) begin
        checks++;
        if (s.in_rdy !== 1'b1) begin
          errors++;
          $display("FAIL stream_in_ready: cycle %0d got %b required 1", k, s.in_rdy);
        end
      end
      if (s.in_fire) begin
        expq.push_back(model(in_a, in_b, in_sub, in_tag));
        nin++;
      end
      if (s.out_fire) begin
        checks++;
        if (expq.size() == 0 || s.res !== expq[0] || k != nout + 2) begin
          errors++;
          $display("FAIL stream_result: cycle %0d got %h required %h at cycle %0d",
                   k, s.res, (expq.size() != 0) ? expq[0] : res_t'(0), nout + 2);
        end
        if (expq.size() != 0) void'(expq.pop_front());
        nout++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nout != 10 || op_count !== CNT_W'(base + 10)) begin
      errors++;
      $display("FAIL stream_count: got %0d results op_count %0d required 10 and %0d",
               nout, op_count, base + 10);
    end
  endtask

  task automatic test_backpressure();
    samp_t s;
    int nacc, nout;
    bit first_rel;
    out_ready = 1'b0;
    expq.delete();
    nacc = 0;
    for (int k = 0; k < 2; k++) begin
      drive(rnd36(), rnd36(), 1'($urandom), 4'(8 + k));
      cycle(s);
      if (s.in_fire) begin
        expq.push_back(model(in_a, in_b, in_sub, in_tag));
        nacc++;
      end
    end
    checks++;
    if (nacc != 2) begin
      errors++;
      $display("FAIL bp_accept_two: got %0d accepted required 2", nacc);
    end
    drive(rnd36(), rnd36(), 1'($urandom), 4'd10);
    for (int k = 0; k < 3; k++) begin
      cycle(s);
      checks++;
      if (s.in_rdy !== 1'b0 || s.in_fire || s.out_vld !== 1'b1 ||
          expq.size() == 0 || s.res !== expq[0]) begin
        errors++;
        $display("FAIL bp_hold: cycle %0d got ready %b valid %b res %h required 0 1 %h",
                 k, s.in_rdy, s.out_vld, s.res, (expq.size() != 0) ? expq[0] : res_t'(0));
      end
    end
    out_ready = 1'b1;
    nout = 0;
    first_rel = 1'b1;
    for (int k = 0; k < 10 && nout < 3; k++) begin
      cycle(s);
      if (first_rel) begin
        checks++;
        if (!s.in_fire) begin
          errors++;
          $display("FAIL bp_third_accept: got in_fire %b required 1", s.in_fire);
        end
        first_rel = 1'b0;
      end
      if (s.in_fire) begin
        expq.push_back(model(in_a, in_b, in_sub, in_tag));
        in_valid = 1'b0;
      end
      if (s.out_fire) begin
        checks++;
        if (expq.size() == 0 || s.res !== expq[0]) begin
          errors++;
          $display("FAIL bp_drain: got %h required %h",
                   s.res, (expq.size() != 0) ? expq[0] : res_t'(0));
        end
        if (expq.size() != 0) void'(expq.pop_front());
        nout++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (nout != 3 || expq.size() != 0) begin
      errors++;
      $display("FAIL bp_count: got %0d drained %0d left required 3 and 0", nout, expq.size());
    end
  endtask

  task automatic test_random();
    samp_t s;
    bit want_rdy;
    expq.delete();
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(9, 0) < 7);
      in_a      = rnd36();
      in_b      = rnd36();
      in_sub    = 1'($urandom);
      in_tag    = 4'($urandom);
      out_ready = (k >= 300) || ($urandom_range(9, 0) < 6);
      if (k >= 300) in_valid = 1'b0;
      want_rdy = !(expq.size() == 2 && !out_ready);
      cycle(s);
      checks++;
      if (s.in_rdy !== want_rdy) begin
        errors++;
        $display("FAIL rand_in_ready: cycle %0d got %b required %b", k, s.in_rdy, want_rdy);
      end
      if (s.out_fire) begin
        checks++;
        if (expq.size() == 0 || s.res !== expq[0]) begin
          errors++;
          $display("FAIL rand_result: cycle %0d got %h required %h",
                   k, s.res, (expq.size() != 0) ? expq[0] : res_t'(0));
        end
        if (expq.size() != 0) void'(expq.pop_front());
      end
      if (s.in_fire) expq.push_back(model(in_a, in_b, in_sub, in_tag));
    end
    in_valid = 1'b0;
    checks++;
    if (expq.size() != 0 || op_count !== CNT_W'(exp_cnt)) begin
      errors++;
      $display("FAIL rand_final: got %0d pending op_count %0d required 0 and %0d",
               expq.size(), op_count, exp_cnt);
    end
  endtask

  task automatic test_reset_midstream();
    samp_t s;
    res_t got, want;
    bit ok;
    out_ready = 1'b0;
    expq.delete();
    for (int k = 0; k < 2; k++) begin
      drive(rnd36(), rnd36(), 1'($urandom), 4'(12 + k));
      cycle(s);
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_full: got valid %b ready %b required 1 0", out_valid, in_ready);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || op_count !== '0) begin
      errors++;
      $display("FAIL midrst_async: got valid %b op_count %0d required 0 0", out_valid, op_count);
    end
    exp_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      cycle(s);
      checks++;
      if (s.out_vld !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale: cycle %0d got out_valid %b required 0", k, s.out_vld);
      end
    end
    run_one(36'h123456789, 36'h0FEDCBA98, 1'b0, 4'd15, got, ok);
    want = model(36'h123456789, 36'h0FEDCBA98, 1'b0, 4'd15);
    checks++;
    if (!ok || got !== want || op_count !== 16'd1) begin
      errors++;
      $display("FAIL midrst_new_op: got %h (done %b) op_count %0d required %h and 1",
               got, ok, op_count, want);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sub_borrow();
    test_carry_overflow();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", checks);
    $fatal(1);
  end

endmodule
